adc_frame_streamer: RTL and testbench

Downstream consumer of the dual-ADC SPI capture stage. It accepts each completed pair of 128-bit ADC frames on the capture stage's one-cycle done pulse and buffers whole frames in a small FIFO. It then unpacks each frame into sixteen 16-bit channel samples and streams them out one per handshake over a valid/ready interface, tagged with channel index and frame sequence number. It also reports full and overflow back to the control logic so acquisition can be throttled.

---
 rtl/adc_pkg.sv | 14 +
 rtl/frame_fifo.sv | 42 ++++
 rtl/adc_frame_streamer.sv | 88 ++++++++
 tb/tb_adc_frame_streamer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared constants, streamer state and channel slicing for the ADC frame streamer.
package adc_pkg;
   localparam int SAMPLE_W   = 16;
   localparam int CH_PER_ADC = 8;
   localparam int NUM_CH     = 16;
   localparam int FRAME_W    = 256;

   typedef enum logic {IDLE, STREAM} strm_state_t;

   // Channel 0 is the MSB-first word of the concatenated {ADC1, ADC2} frame.
   function automatic logic [SAMPLE_W-1:0] chan_slice(input logic [FRAME_W-1:0] frame, input logic [3:0] ch);
      return frame[FRAME_W-1-SAMPLE_W*int'(ch) -: SAMPLE_W];
   endfunction
endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: synchronous FIFO of whole frames with full/empty flags and an occupancy count.
module frame_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH+1)
) (
   input  logic          i_Clk,
   input  logic          i_Reset_n,
   input  logic          i_Push,
   input  logic [W-1:0]  i_Wr_Data,
   input  logic          i_Pop,
   output logic [W-1:0]  o_Rd_Data,
   output logic          o_Full,
   output logic          o_Empty,
   output logic [CW-1:0] o_Count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          wr, rd;

   // A push into a full FIFO is legal when a pop frees the slot on the same edge.
   assign wr        = i_Push && (!o_Full || i_Pop);
   assign rd        = i_Pop && !o_Empty;
   assign o_Full    = o_Count == CW'(DEPTH);
   assign o_Empty   = o_Count == '0;
   assign o_Rd_Data = mem[rd_ptr];

   always_ff @(posedge i_Clk)
      if (wr) mem[wr_ptr] <= i_Wr_Data;

   always_ff @(posedge i_Clk or negedge i_Reset_n)
      if (!i_Reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_Count <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         o_Count <= o_Count + CW'(wr) - CW'(rd);
      end
endmodule

// File: rtl/adc_frame_streamer.sv
// adc_frame_streamer: buffers dual-ADC frames and streams them as tagged 16-bit samples over valid/ready.
module adc_frame_streamer
   import adc_pkg::*;
#(
   parameter  int FRAME_DEPTH = 4,
   parameter  int SEQ_W       = 8,
   localparam int CW          = $clog2(FRAME_DEPTH+1)
) (
   input  logic                i_Clk,
   input  logic                i_Reset_n,
   input  logic [127:0]        i_Data1,
   input  logic [127:0]        i_Data2,
   input  logic                i_Done,
   output logic [SAMPLE_W-1:0] o_Sample,
   output logic [3:0]          o_Chan,
   output logic [SEQ_W-1:0]    o_Seq,
   output logic                o_Last,
   output logic                o_Valid,
   input  logic                i_Ready,
   output logic                o_Full,
   output logic [CW-1:0]       o_Pending,
   output logic                o_Overflow,
   input  logic                i_Clear_Ovf,
   output logic [7:0]          o_Drop_Count
);
   localparam int EW = FRAME_W + SEQ_W;

   strm_state_t        state, state_nx;
   logic [SEQ_W-1:0]   seq_cnt, hold_seq;
   logic [FRAME_W-1:0] hold;
   logic [3:0]         chan;
   logic [EW-1:0]      rd_data;
   logic               empty, hs, last_hs, pop, push, drop;

   assign o_Valid = state == STREAM;
   assign hs      = o_Valid && i_Ready;
   assign last_hs = hs && chan == 4'(NUM_CH-1);
   // Popping on the last handshake lets the next frame follow with no bubble.
   assign pop     = !empty && (state == IDLE || last_hs);
   assign push    = i_Done && (!o_Full || pop);
   assign drop    = i_Done && !push;

   assign o_Sample = chan_slice(hold, chan);
   assign o_Chan   = chan;
   assign o_Seq    = hold_seq;
   assign o_Last   = o_Valid && chan == 4'(NUM_CH-1);

   frame_fifo #(.W(EW), .DEPTH(FRAME_DEPTH)) u_fifo (
      .i_Clk     (i_Clk),
      .i_Reset_n (i_Reset_n),
      .i_Push    (push),
      .i_Wr_Data ({seq_cnt, i_Data1, i_Data2}),
      .i_Pop     (pop),
      .o_Rd_Data (rd_data),
      .o_Full    (o_Full),
      .o_Empty   (empty),
      .o_Count   (o_Pending)
   );

   always_comb begin
      state_nx = state;
      if (state == IDLE) state_nx = empty ? IDLE : STREAM;
      else               state_nx = (last_hs && empty) ? IDLE : STREAM;
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n)
      if (!i_Reset_n) state <= IDLE;
      else            state <= state_nx;

   always_ff @(posedge i_Clk or negedge i_Reset_n)
      if (!i_Reset_n) begin
         hold         <= '0;
         hold_seq     <= '0;
         chan         <= '0;
         seq_cnt      <= '0;
         o_Overflow   <= 1'b0;
         o_Drop_Count <= '0;
      end else begin
         if (pop) begin
            {hold_seq, hold} <= rd_data;
            chan             <= '0;
         end else if (hs) chan <= chan + 4'd1;
         // Dropped frames still consume a sequence number so the consumer sees the gap.
         if (i_Done) seq_cnt <= seq_cnt + SEQ_W'(1);
         o_Overflow <= drop || (o_Overflow && !i_Clear_Ovf);
         if (drop && o_Drop_Count != 8'hFF) o_Drop_Count <= o_Drop_Count + 8'd1;
      end
endmodule

// File: tb/tb_adc_frame_streamer.sv
// tb_adc_frame_streamer: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_adc_frame_streamer;
   localparam int DEPTH = 4;
   localparam int SEQ_W = 8;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 0, rst_n = 0;
   logic [127:0]  d1 = '0, d2 = '0;
   logic          done = 0, ready = 0, clr = 0;
   logic [15:0]   o_sample;
   logic [3:0]    o_chan;
   logic [7:0]    o_seq;
   logic          o_last, o_valid, o_full, o_overflow;
   logic [CW-1:0] o_pending;
   logic [7:0]    o_drop_count;

   typedef struct packed {logic [15:0] s; logic [3:0] c; logic [7:0] q; logic l;} exp_t;
   exp_t       sb[$];
   exp_t       cur, held;
   logic       stalled = 0;
   logic [7:0] exp_seq = 0;
   int         n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   adc_frame_streamer #(.FRAME_DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_Data1(d1), .i_Data2(d2), .i_Done(done),
      .o_Sample(o_sample), .o_Chan(o_chan), .o_Seq(o_seq), .o_Last(o_last), .o_Valid(o_valid),
      .i_Ready(ready), .o_Full(o_full), .o_Pending(o_pending), .o_Overflow(o_overflow),
      .i_Clear_Ovf(clr), .o_Drop_Count(o_drop_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) stalled = 0;
      else begin
         cur = {o_sample, o_chan, o_seq, o_last};
         if (stalled && o_valid) check("hold_stable", cur, held);
         if (o_valid && ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_sample: got %0h expected none", cur);
            end else check("sample", cur, sb.pop_front());
         end
         stalled = o_valid && !ready;
         held    = cur;
      end
   end

   task automatic send(input logic [15:0] base, input logic keep, input logic with_clr);
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         d1[127-16*k -: 16] = base + 16'(k);
         d2[127-16*k -: 16] = base + 16'(k+8);
      end
      done = 1;
      clr  = with_clr;
      if (keep) for (int k = 0; k < 16; k++) sb.push_back(exp_t'({base + 16'(k), 4'(k), exp_seq, k == 15}));
      exp_seq++;
      @(posedge clk); #1;
      done = 0;
      clr  = 0;
   endtask

   task automatic drain(input string name, input int max);
      int n = 0;
      while (sb.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      rst_n = 0;
      sb.delete();
      exp_seq = 0;
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] pat;
      int first, last_i, cnt, n;
      pat = 4'b1001;
      #2;
      check("rst_outputs", {o_sample, o_chan, o_seq, o_last, o_valid, o_full, o_overflow}, 0);
      check("rst_counts", {o_pending, o_drop_count}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      ready = 1;

      send(16'h0000, 1, 0);
      check("pending_after_done", o_pending, 1);
      check("valid_edge_n", o_valid, 0);
      @(posedge clk); #1;
      check("valid_edge_n1", o_valid, 1);
      check("pending_after_pop", o_pending, 0);
      drain("single_drain", 40);

      send(16'h1000, 1, 0);
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
         ready = pat[i%4];
      end
      ready = 1;
      drain("backpressure_drain", 10);

      first = -1; last_i = -1; cnt = 0;
      fork
         begin
            send(16'h2000, 1, 0);
            @(posedge clk);
            send(16'h3000, 1, 0);
         end
         for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (o_valid) begin
               cnt++;
               if (first < 0) first = i;
               last_i = i;
            end
         end
      join
      check("b2b_valid_count", cnt, 32);
      check("b2b_no_gap", last_i - first + 1, 32);
      drain("b2b_drain", 10);

      reset_dut();
      ready = 0;
      for (int i = 0; i < 5; i++) send(16'h4000 + 16'(i*256), 1, 0);
      check("fill_pending", o_pending, 4);
      check("fill_full", o_full, 1);
      check("fill_no_ovf", o_overflow, 0);
      send(16'h4500, 0, 1);
      check("drop_set_wins", o_overflow, 1);
      check("drop_count", o_drop_count, 1);
      check("drop_pending", o_pending, 4);
      @(posedge clk); #1;
      clr = 1;
      @(posedge clk); #1;
      clr = 0;
      check("ovf_cleared", o_overflow, 0);
      check("drop_count_kept", o_drop_count, 1);
      ready = 1;
      drain("overflow_drain", 200);
      send(16'h4600, 1, 0);
      drain("seq_gap_drain", 40);

      send(16'h8000, 1, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(o_valid && o_chan == 4'd7) && n < 40);
      check("reach_ch7", {o_valid, o_chan}, {1'b1, 4'd7});
      #2 rst_n = 0;
      #1;
      check("midrst_outputs", {o_sample, o_chan, o_seq, o_last, o_valid, o_full, o_overflow}, 0);
      check("midrst_counts", {o_pending, o_drop_count}, 0);
      sb.delete();
      exp_seq = 0;
      @(posedge clk); #1;
      rst_n = 1;
      send(16'hA000, 1, 0);
      drain("post_reset_drain", 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
